// File: rtl/pclk_monitor.sv
// Samples a slow clock-like input in the clk domain. Produces rise/fall enable ticks,
// measures the rising-to-rising period and reports lock and loss-of-clock status.
module pclk_monitor #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned TOL         = 1,
   parameter int unsigned LOCK_COUNT  = 4,
   parameter int unsigned TIMEOUT     = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pclk_in,
   input  logic             clear_lost,
   output logic             rise_tick,
   output logic             fall_tick,
   output logic [CNT_W-1:0] period,
   output logic             locked,
   output logic             lost
);

   localparam int unsigned MC_W = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0] TOL_V   = CNT_W'(TOL);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [MC_W-1:0]  LC_LAST = MC_W'(LOCK_COUNT - 1);
   localparam logic [MC_W-1:0]  LC_FULL = MC_W'(LOCK_COUNT);

   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

   state_t               state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                 prev;
   logic                 sync_s;
   logic                 rise;
   logic                 fall;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     meas;
   logic [CNT_W-1:0]     ref_q;
   logic [CNT_W-1:0]     diff;
   logic [MC_W-1:0]      match_cnt;
   logic                 have_ref;
   logic                 match;
   logic                 timeout;

   assign sync_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      rise    = sync_s & ~prev;
      fall    = ~sync_s & prev;
      meas    = cnt + CNT_W'(1);
      diff    = (meas >= ref_q) ? (meas - ref_q) : (ref_q - meas);
      match   = (diff <= TOL_V);
      // a rise landing in the last counted cycle wins over the timeout
      timeout = (state != IDLE) && (cnt == TO_LAST) && !rise;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '0;
         prev      <= 1'b0;
         rise_tick <= 1'b0;
         fall_tick <= 1'b0;
         cnt       <= '0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], pclk_in};
         prev      <= sync_s;
         rise_tick <= rise;
         fall_tick <= fall;
         if (rise)
            cnt <= '0;
         else if (cnt != '1)
            cnt <= cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ref_q     <= '0;
         period    <= '0;
         match_cnt <= '0;
         have_ref  <= 1'b0;
         locked    <= 1'b0;
         lost      <= 1'b0;
      end else begin
         if (timeout) begin
            state     <= IDLE;
            locked    <= 1'b0;
            match_cnt <= '0;
         end else if (rise) begin
            case (state)
               IDLE: begin
                  state     <= ACQUIRE;
                  have_ref  <= 1'b0;
                  match_cnt <= '0;
               end
               ACQUIRE: begin
                  ref_q    <= meas;
                  period   <= meas;
                  have_ref <= 1'b1;
                  if (!have_ref || !match) begin
                     match_cnt <= '0;
                  end else if (match_cnt == LC_LAST) begin
                     match_cnt <= LC_FULL;
                     state     <= LOCKED;
                     locked    <= 1'b1;
                  end else begin
                     match_cnt <= match_cnt + MC_W'(1);
                  end
               end
               LOCKED: begin
                  ref_q  <= meas;
                  period <= meas;
                  if (!match) begin
                     state     <= ACQUIRE;
                     locked    <= 1'b0;
                     match_cnt <= '0;
                  end
               end
               default: state <= IDLE;
            endcase
         end

         if (timeout && (state == LOCKED))
            lost <= 1'b1;
         else if (clear_lost)
            lost <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pclk_monitor.sv
// Bench for pclk_monitor: table of pclk_in periods with expected period/locked per rise tick,
// checked through a scoreboard queue, plus hand sequences for timeout, lost and reset.
`timescale 1ns/1ps
module tb_pclk_monitor;

   localparam int TIMEOUT = 1024;

   typedef struct {
      int hi;
      int lo;
      int gap;
      int per;
      bit lk;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pclk_in = 1'b0;
   logic        clear_lost = 1'b0;
   logic        rise_tick;
   logic        fall_tick;
   logic [15:0] period;
   logic        locked;
   logic        lost;

   int   nchecks = 0;
   int   nerrors = 0;
   int   cyc = 0;
   int   last_rise = 0;
   int   cur_hi = 0;
   int   locked_cyc = 0;
   int   lost_cyc = 0;
   vec_t vecs [34];
   vec_t exp_q [$];
   vec_t mon_e;

   pclk_monitor #(
      .SYNC_STAGES(2),
      .CNT_W(16),
      .TOL(1),
      .LOCK_COUNT(4),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .pclk_in(pclk_in),
      .clear_lost(clear_lost),
      .rise_tick(rise_tick),
      .fall_tick(fall_tick),
      .period(period),
      .locked(locked),
      .lost(lost)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic vec_t mk(input int hi_c, input int lo_c, input int gap_c,
                               input int per_c, input bit lk_c);
      vec_t v;
      v.hi = hi_c; v.lo = lo_c; v.gap = gap_c; v.per = per_c; v.lk = lk_c;
      return v;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      nchecks++;
      if (act != exp) begin
         nerrors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // called at a negedge; each row is hi cycles high then lo cycles low
   task automatic run_rows(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         pclk_in = 1'b1;
         exp_q.push_back(vecs[i]);
         repeat (vecs[i].hi) @(negedge clk);
         pclk_in = 1'b0;
         repeat (vecs[i].lo) @(negedge clk);
      end
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // scoreboard monitor
   initial forever begin
      @(negedge clk);
      if (rise_tick || fall_tick) check("tick_overlap", rise_tick & fall_tick, 0);
      if (locked) locked_cyc++;
      if (lost) lost_cyc++;
      if (rise_tick) begin
         if (exp_q.size() == 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL unexpected_rise: got rise_tick=1 expected no tick (cycle %0d)", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            check("tick_period", period, mon_e.per);
            check("tick_locked", locked, mon_e.lk);
            check("tick_lost", lost, 0);
            if (mon_e.gap != 0) check("rise_gap", cyc - last_rise, mon_e.gap);
            cur_hi = mon_e.hi;
         end
         last_rise = cyc;
      end
      if (fall_tick && cur_hi != 0) check("fall_spacing", cyc - last_rise, cur_hi);
   end

   initial begin
      #500us;
      $display("FAIL watchdog: got no completion expected finish before 500us");
      $fatal(1);
   end

   initial begin
      int t;
      int c0;
      int lk0;
      int ls0;

      // divide-by-4 acquisition from reset, lock on the 6th tick
      vecs[0]  = mk(2, 2, 0, 0, 0);
      for (int i = 1; i <= 4; i++) vecs[i] = mk(2, 2, 4, 4, 0);
      vecs[5]  = mk(2, 2, 4, 4, 1);
      vecs[6]  = mk(2, 2, 4, 4, 1);
      // relock after timeout; period retained across IDLE
      vecs[7]  = mk(2, 2, 0, 4, 0);
      for (int i = 8; i <= 11; i++) vecs[i] = mk(2, 2, 4, 4, 0);
      vecs[12] = mk(2, 2, 4, 4, 1);
      vecs[13] = mk(2, 2, 0, 4, 0);
      for (int i = 14; i <= 17; i++) vecs[i] = mk(2, 2, 4, 4, 0);
      vecs[18] = mk(2, 2, 4, 4, 1);
      // jitter 4,5,4,5 stays locked, then 7 unlocks and four more 7s relock
      vecs[19] = mk(2, 3, 4, 4, 1);
      vecs[20] = mk(2, 2, 5, 5, 1);
      vecs[21] = mk(2, 3, 4, 4, 1);
      vecs[22] = mk(3, 4, 5, 5, 1);
      vecs[23] = mk(3, 4, 7, 7, 0);
      for (int i = 24; i <= 26; i++) vecs[i] = mk(3, 4, 7, 7, 0);
      vecs[27] = mk(3, 4, 7, 7, 1);
      // period 2000 > TIMEOUT never locks
      vecs[28] = mk(1000, 1000, 0, 0, 0);
      vecs[29] = mk(1000, 1000, 2000, 0, 0);
      vecs[30] = mk(1000, 1000, 2000, 0, 0);
      // rise exactly at cnt == TIMEOUT-1 in ACQUIRE
      vecs[31] = mk(2, TIMEOUT - 2, 2000, 0, 0);
      vecs[32] = mk(2, 2, TIMEOUT, TIMEOUT, 0);
      vecs[33] = mk(2, 2, 4, 4, 0);

      repeat (3) @(negedge clk);
      check("reset_rise_tick", rise_tick, 0);
      check("reset_fall_tick", fall_tick, 0);
      check("reset_period", period, 0);
      check("reset_locked", locked, 0);
      check("reset_lost", lost, 0);
      rst_n = 1'b1;

      run_rows(0, 6);
      check("pending_lock4", exp_q.size(), 0);

      t = last_rise + TIMEOUT - 1;
      wait_cyc(t);
      check("pre_timeout_locked", locked, 1);
      check("pre_timeout_lost", lost, 0);
      @(negedge clk);
      check("timeout_locked", locked, 0);
      check("timeout_lost", lost, 1);
      check("timeout_period", period, 4);
      @(negedge clk);
      check("lost_sticky", lost, 1);
      clear_lost = 1'b1;
      @(negedge clk);
      clear_lost = 1'b0;
      check("lost_cleared", lost, 0);

      run_rows(7, 12);
      check("pending_relock", exp_q.size(), 0);
      t = last_rise + TIMEOUT - 1;
      wait_cyc(t);
      check("pre_timeout2_locked", locked, 1);
      clear_lost = 1'b1;
      @(negedge clk);
      clear_lost = 1'b0;
      check("lost_set_wins", lost, 1);
      check("timeout2_locked", locked, 0);
      @(negedge clk);
      check("lost_sticky2", lost, 1);
      clear_lost = 1'b1;
      @(negedge clk);
      clear_lost = 1'b0;
      check("lost_cleared2", lost, 0);

      run_rows(13, 27);
      check("pending_jitter", exp_q.size(), 0);

      pclk_in = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_rise_tick", rise_tick, 0);
      check("async_rst_fall_tick", fall_tick, 0);
      check("async_rst_period", period, 0);
      check("async_rst_locked", locked, 0);
      check("async_rst_lost", lost, 0);
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      c0 = cyc;
      wait_cyc(c0 + 2);
      check("rst_tick_early", rise_tick, 0);
      @(negedge clk);
      check("rst_tick_edge3", rise_tick, 1);
      @(negedge clk);
      check("rst_tick_single", rise_tick, 0);
      repeat (10) @(negedge clk);
      lk0 = locked_cyc;
      ls0 = lost_cyc;
      pclk_in = 1'b0;
      repeat (1500) @(negedge clk);
      check("pending_reset", exp_q.size(), 0);

      run_rows(28, 30);
      check("slow_never_locked", locked_cyc - lk0, 0);
      check("slow_never_lost", lost_cyc - ls0, 0);
      check("pending_slow", exp_q.size(), 0);

      run_rows(31, 33);
      repeat (5) @(negedge clk);
      check("pending_final", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
      $finish;
   end

endmodule
